// File: rtl/tim_input_filter_ctrl.sv
// Timer input-capture filter: synchronises TIx, samples at the ICxF-selected rate and only
// accepts a new level after N consecutive disagreeing samples; emits registered edge pulses.
module tim_input_filter_ctrl #(
  parameter int CHANNELS = 4
) (
  input  logic                    clk_i,
  input  logic                    aresetn_i,
  input  logic [1:0]              ckd_i,
  input  logic [4*CHANNELS-1:0]   icf_i,
  input  logic [CHANNELS-1:0]     ti_i,
  output logic [CHANNELS-1:0]     tif_o,
  output logic [CHANNELS-1:0]     rise_o,
  output logic [CHANNELS-1:0]     fall_o
);

  logic [CHANNELS-1:0]        sync1_q, sync2_q;
  logic [1:0]                 ckd_q;
  logic [4*CHANNELS-1:0]      icf_q;
  logic [1:0]                 pre_q, pre_d;
  logic [4:0]                 div_q, div_d;
  logic [CHANNELS-1:0][2:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0]        tif_q, tif_d;
  logic [CHANNELS-1:0]        rise_q, rise_d;
  logic [CHANNELS-1:0]        fall_q, fall_d;
  logic                       ckd_chg;
  logic                       dts_tick;
  logic [CHANNELS-1:0]        strobe;

  // Event count N required to accept a new level.
  function automatic logic [3:0] filt_n(input logic [3:0] code);
    case (code)
      4'h0:                      filt_n = 4'd1;
      4'h1:                      filt_n = 4'd2;
      4'h2:                      filt_n = 4'd4;
      4'h3, 4'h5, 4'h7, 4'h9,
      4'hC, 4'hF:                filt_n = 4'd8;
      4'hA, 4'hD:                filt_n = 4'd5;
      default:                   filt_n = 4'd6;
    endcase
  endfunction

  // Sampling strobe for a code, given the shared DTS tick and divider.
  function automatic logic filt_strobe(input logic [3:0] code, input logic tick,
                                       input logic [4:0] div);
    case (code)
      4'h0:             filt_strobe = tick;
      4'h1, 4'h2, 4'h3: filt_strobe = 1'b1;
      4'h4, 4'h5:       filt_strobe = tick & div[0];
      4'h6, 4'h7:       filt_strobe = tick & (&div[1:0]);
      4'h8, 4'h9:       filt_strobe = tick & (&div[2:0]);
      4'hA, 4'hB, 4'hC: filt_strobe = tick & (&div[3:0]);
      default:          filt_strobe = tick & (&div[4:0]);
    endcase
  endfunction

  assign ckd_chg = (ckd_i != ckd_q);

  always_comb begin
    case (ckd_q)
      2'b01:   dts_tick = pre_q[0];
      2'b10:   dts_tick = &pre_q;
      default: dts_tick = 1'b1;
    endcase
    pre_d = ckd_chg ? 2'd0 : pre_q + 2'd1;
    div_d = ckd_chg ? 5'd0 : (dts_tick ? div_q + 5'd1 : div_q);
  end

  always_comb begin
    cnt_d  = cnt_q;
    tif_d  = tif_q;
    strobe = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      strobe[c] = filt_strobe(icf_q[4*c +: 4], dts_tick, div_q);
      // A config change on either the channel or the DTS divider wins over sampling.
      if (ckd_chg || (icf_i[4*c +: 4] != icf_q[4*c +: 4])) begin
        cnt_d[c] = 3'd0;
      end else if (strobe[c]) begin
        if (sync2_q[c] == tif_q[c]) begin
          cnt_d[c] = 3'd0;
        end else if ({1'b0, cnt_q[c]} + 4'd1 == filt_n(icf_q[4*c +: 4])) begin
          tif_d[c] = sync2_q[c];
          cnt_d[c] = 3'd0;
        end else begin
          cnt_d[c] = cnt_q[c] + 3'd1;
        end
      end
    end
    rise_d = tif_d & ~tif_q;
    fall_d = ~tif_d & tif_q;
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      ckd_q   <= '0;
      icf_q   <= '0;
      pre_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      tif_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      sync1_q <= ti_i;
      sync2_q <= sync1_q;
      ckd_q   <= ckd_i;
      icf_q   <= icf_i;
      pre_q   <= pre_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      tif_q   <= tif_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign tif_o  = tif_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_tim_input_filter_ctrl.sv
// Bench for tim_input_filter_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a rate/run-length model of the filter.
module tb_tim_input_filter_ctrl;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [1:0]    ckd = 2'b00;
  logic [4*CH-1:0] icf = '0;
  logic [CH-1:0] ti = '0;
  logic [CH-1:0] tif, rise, fall;

  int tests = 0;
  int fails = 0;

  tim_input_filter_ctrl #(.CHANNELS(CH)) dut (
    .clk_i(clk), .aresetn_i(rstn), .ckd_i(ckd), .icf_i(icf), .ti_i(ti),
    .tif_o(tif), .rise_o(rise), .fall_o(fall)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int      t;
  bit [1:0] m_ckd;
  bit [3:0] m_icf [CH];
  bit      sy1 [CH], sy2 [CH];
  int      run [CH];
  bit      m_tif [CH], m_rise [CH], m_fall [CH];

  function automatic int n_of(input bit [3:0] code);
    int tbl [16] = '{1, 2, 4, 8, 6, 8, 6, 8, 6, 8, 5, 6, 8, 5, 6, 8};
    return tbl[code];
  endfunction

  // Strobe every k DTS periods, aligned so the first one lands on the k-th tick.
  function automatic bit m_strobe(input bit [3:0] code, input int tt, input int p);
    bit tick;
    int k;
    tick = ((tt % p) == p - 1);
    if (code == 0) return tick;
    if (code <= 3) return 1'b1;
    k = (code <= 5) ? 2 : (code <= 7) ? 4 : (code <= 9) ? 8 : (code <= 12) ? 16 : 32;
    return tick && (((tt / p) % k) == k - 1);
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t = 0;
      m_ckd = 0;
      for (int c = 0; c < CH; c++) begin
        m_icf[c] = 0; sy1[c] = 0; sy2[c] = 0; run[c] = 0;
        m_tif[c] = 0; m_rise[c] = 0; m_fall[c] = 0;
      end
    end else begin
      bit chg;
      int p;
      chg = (ckd != m_ckd);
      p = (m_ckd == 2'b01) ? 2 : (m_ckd == 2'b10) ? 4 : 1;
      for (int c = 0; c < CH; c++) begin
        m_rise[c] = 0;
        m_fall[c] = 0;
        if (chg || (icf[4*c +: 4] != m_icf[c])) begin
          run[c] = 0;
        end else if (m_strobe(m_icf[c], t, p)) begin
          if (sy2[c] == m_tif[c]) run[c] = 0;
          else if (run[c] + 1 == n_of(m_icf[c])) begin
            m_tif[c] = sy2[c];
            m_rise[c] = sy2[c];
            m_fall[c] = !sy2[c];
            run[c] = 0;
          end else run[c] = run[c] + 1;
        end
        sy2[c] = sy1[c];
        sy1[c] = ti[c];
        m_icf[c] = icf[4*c +: 4];
      end
      m_ckd = ckd;
      t = chg ? 0 : t + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rstn) begin
      for (int c = 0; c < CH; c++) begin
        tests++;
        if (tif[c] !== m_tif[c] || rise[c] !== m_rise[c] || fall[c] !== m_fall[c]) begin
          fails++;
          $display("FAIL model ch%0d t=%0t: tif/rise/fall got %b%b%b expected %b%b%b",
                   c, $time, tif[c], rise[c], fall[c], m_tif[c], m_rise[c], m_fall[c]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold [CH];
    #3 rstn = 1'b0;
    #1;
    chk("reset_tif", 32'(tif), 0);
    chk("reset_pulses", 32'({rise, fall}), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Directed: fCK, N=2 -> new level 4 edges after the ti change.
    icf = 16'h0001;
    edges(3);
    ti[0] = 1'b1;
    edges(3);
    chk("t1_before", 32'(tif[0]), 0);
    edges(1);
    chk("t1_tif", 32'(tif[0]), 1);
    chk("t1_rise", 32'(rise[0]), 1);
    edges(1);
    chk("t1_rise_end", 32'(rise[0]), 0);
    ti[0] = 1'b0;
    edges(4);
    chk("t1_fall", 32'(fall[0]), 1);
    chk("t1_low", 32'(tif[0]), 0);

    // Directed: N=8, a 7-clock glitch is rejected, an 8-clock pulse is accepted.
    icf = 16'h0003;
    edges(3);
    ti[0] = 1'b1;
    edges(7);
    ti[0] = 1'b0;
    edges(12);
    chk("t2_glitch", 32'(tif[0]), 0);
    ti[0] = 1'b1;
    edges(9);
    chk("t2_before", 32'(tif[0]), 0);
    edges(1);
    chk("t2_tif", 32'(tif[0]), 1);

    // Directed: config change mid-count restarts with the new N.
    ti[0] = 1'b0;
    edges(7);
    chk("t5_cnt5", 32'(tif[0]), 1);
    icf = 16'h0001;
    edges(2);
    chk("t5_held", 32'(tif[0]), 1);
    edges(1);
    chk("t5_switch", 32'(tif[0]), 0);
    ti[0] = 1'b1;
    edges(4);
    chk("t6_pre", 32'(tif[0]), 1);

    // Directed: asynchronous reset mid-count.
    ti[0] = 1'b0;
    edges(1);
    #2 rstn = 1'b0;
    #1;
    chk("t6_tif", 32'(tif), 0);
    chk("t6_pulses", 32'({rise, fall}), 0);
    @(negedge clk);
    rstn = 1'b1;
    edges(3);
    ti[0] = 1'b1;
    edges(4);
    chk("t6_after", 32'(tif[0]), 1);

    // Randomized phases checked by the model every cycle.
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int ph = 0; ph < 26; ph++) begin
      int len;
      ckd = 2'($urandom_range(0, 3));
      icf = 16'($urandom);
      len = $urandom_range(300, 700);
      for (int i = 0; i < len; i++) begin
        for (int c = 0; c < CH; c++) begin
          hold[c]--;
          if (hold[c] <= 0) begin
            ti[c] = ~ti[c];
            hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12)
                                                  : $urandom_range(10, 400);
          end
        end
        if ($urandom_range(0, 299) == 0) icf[4*$urandom_range(0, CH-1) +: 4] = 4'($urandom);
        if ($urandom_range(0, 999) == 0) ckd = 2'($urandom);
        if (ph == 13 && i == 200) begin
          #2 rstn = 1'b0;
          #1;
          chk("rand_reset", 32'({tif, rise, fall}), 0);
          @(negedge clk);
          rstn = 1'b1;
        end
        @(negedge clk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
